fu_mem_pipe: RTL and testbench

- Parametrised successor to the team's memory functional unit: one load/store per request against an internal byte-addressable RAM.
- Configurable access latency and RAM size.
- Full RV32 byte/half/word semantics: byte-enabled stores, sign/zero-extended loads.
- Explicit busy/done handshake and a misalignment/illegal-op flag.
- Sits in the execute stage beside the ALU/MUL FUs; the issue logic drives EN and waits for done.

---
 rtl/fu_mem_pipe_if.sv | 30 +++
 rtl/fu_mem_pipe.sv | 148 ++++++++++++++
 tb/tb_fu_mem_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_mem_pipe_if.sv
// ---------------------------------------------------------------------------
// fu_mem_pipe_if : request/response bundle between issue logic and the memory FU
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fu_mem_pipe_if;
  logic        en;
  logic        mem_w;
  logic [2:0]  bhw;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic        misalign;

  modport master (
    output en, mem_w, bhw, rs1_data, rs2_data, imm,
    input  mem_data, busy, done, misalign
  );

  modport slave (
    input  en, mem_w, bhw, rs1_data, rs2_data, imm,
    output mem_data, busy, done, misalign
  );
endinterface

`default_nettype wire

// File: rtl/fu_mem_pipe.sv
// ---------------------------------------------------------------------------
// fu_mem_pipe : fixed-latency RV32 load/store unit on an internal byte RAM
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fu_mem_pipe #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fu_mem_pipe_if.slave  bus
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CNT_W = $clog2(LATENCY + 1);

  if (LATENCY < 2) begin : g_bad_latency
    $error("fu_mem_pipe: LATENCY must be >= 2");
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 20) begin : g_bad_addr_width
    $error("fu_mem_pipe: ADDR_WIDTH must be within 3..20");
  end

  logic [31:0]           r_ram [DEPTH];
  logic                  r_busy, r_done, r_mis, r_mem_w;
  logic [31:0]           r_mem_data, r_rs2;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_bhw;
  logic [ADDR_WIDTH-1:0] r_rs1, r_imm;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_access, w_legal, w_aligned, w_ok;
  logic [31:0]           w_word, w_load, w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_be;

  // Only the low ADDR_WIDTH bits of the sum matter, so the adder is kept narrow.
  assign w_addr   = r_rs1 + r_imm;
  assign w_idx    = w_addr[ADDR_WIDTH-1:2];
  assign w_lane   = w_addr[1:0];
  assign w_word   = r_ram[w_idx];
  assign w_access = r_busy && (r_cnt == CNT_W'(1));
  assign w_ok     = w_legal && w_aligned;

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = r_rs2;
    w_byte    = w_word[7:0];
    w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_load    = w_word;

    if (r_mem_w)
      w_legal = (r_bhw == 3'b000) || (r_bhw == 3'b001) || (r_bhw == 3'b010);
    else
      w_legal = (r_bhw != 3'b011) && (r_bhw != 3'b110) && (r_bhw != 3'b111);

    case (r_bhw[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{r_rs2[7:0]}};
      end
      2'b01: begin
        w_aligned = ~w_lane[0];
        w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{r_rs2[15:0]}};
      end
      default: w_aligned = (w_lane == 2'b00);
    endcase

    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase

    case (r_bhw)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_mem_data <= '0;
      r_cnt      <= '0;
      r_mem_w    <= 1'b0;
      r_bhw      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      if (!r_busy) begin
        if (bus.en) begin
          r_busy  <= 1'b1;
          r_cnt   <= CNT_W'(LATENCY - 1);
          r_mem_w <= bus.mem_w;
          r_bhw   <= bus.bhw;
          r_rs1   <= bus.rs1_data[ADDR_WIDTH-1:0];
          r_rs2   <= bus.rs2_data;
          r_imm   <= bus.imm[ADDR_WIDTH-1:0];
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_access) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_mis  <= ~w_ok;
          if (!r_mem_w && w_ok)
            r_mem_data <= w_load;
        end
      end
    end
  end

  // RAM is deliberately outside the reset domain; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst && w_access && r_mem_w && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          r_ram[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign bus.mem_data = r_mem_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.misalign = r_mis;

endmodule

`default_nettype wire

// File: tb/tb_fu_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_fu_mem_pipe : bench for fu_mem_pipe at LATENCY 2 and 4
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fu_mem_pipe;

  logic clk = 1'b0;
  logic rst2, rst4;
  always #5 clk = ~clk;

  fu_mem_pipe_if bus2 ();
  fu_mem_pipe_if bus4 ();

  fu_mem_pipe #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));
  fu_mem_pipe #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        w;
    logic [2:0]  bhw;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  exp_t q2[$];
  exp_t q4[$];
  vec_t vt[25];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic en, input logic w, input logic [2:0] bhw,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    if (!sel) begin
      bus2.en = en; bus2.mem_w = w; bus2.bhw = bhw;
      bus2.rs1_data = rs1; bus2.rs2_data = rs2; bus2.imm = imm;
    end else begin
      bus4.en = en; bus4.mem_w = w; bus4.bhw = bhw;
      bus4.rs1_data = rs1; bus4.rs2_data = rs2; bus4.imm = imm;
    end
  endtask

  function automatic logic [31:0] status(input bit sel);
    return sel ? {30'b0, bus4.done, bus4.busy} : {30'b0, bus2.done, bus2.busy};
  endfunction

  // Scoreboard consumers: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (bus2.done === 1'b1) begin
      if (q2.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL dut2_unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("dut2_data", bus2.mem_data, e.data);
        check("dut2_misalign", {31'b0, bus2.misalign}, {31'b0, e.mis});
      end
    end else begin
      check("dut2_misalign_idle", {31'b0, bus2.misalign}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (bus4.done === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL dut4_unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("dut4_data", bus4.mem_data, e.data);
        check("dut4_misalign", {31'b0, bus4.misalign}, {31'b0, e.mis});
      end
    end else begin
      check("dut4_misalign_idle", {31'b0, bus4.misalign}, 32'd0);
    end
  end

  task automatic run_op(input bit sel, input logic w, input logic [2:0] bhw,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_data, input logic exp_mis);
    int   lat;
    exp_t e;
    lat = sel ? 4 : 2;
    @(negedge clk);
    set_req(sel, 1'b1, w, bhw, rs1, rs2, imm);
    e.data = exp_data;
    e.mis  = exp_mis;
    if (sel) q4.push_back(e); else q2.push_back(e);
    @(posedge clk); #1;
    set_req(sel, 1'b0, w, bhw, rs1, rs2, imm);
    check("accept_busy", status(sel), 32'b01);
    repeat (lat - 1) @(posedge clk);
    #1;
    check("done_timing", status(sel), 32'b10);
  endtask

  initial begin
    vt[0]  = '{1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0,        32'h00000000, 1'b0};
    vt[1]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h4,        32'h00000000, 1'b0};
    vt[2]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h4,        32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b0, 3'b000, 32'h107, 32'h0,        32'h0,        32'hFFFFFFDE, 1'b0};
    vt[4]  = '{1'b0, 3'b100, 32'h107, 32'h0,        32'h0,        32'h000000DE, 1'b0};
    vt[5]  = '{1'b0, 3'b001, 32'h104, 32'h0,        32'h0,        32'hFFFFBEEF, 1'b0};
    vt[6]  = '{1'b0, 3'b101, 32'h106, 32'h0,        32'h0,        32'h0000DEAD, 1'b0};
    vt[7]  = '{1'b1, 3'b000, 32'h105, 32'hAAAAAA55, 32'h0,        32'h0000DEAD, 1'b0};
    vt[8]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h0,        32'hDEAD55EF, 1'b0};
    vt[9]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        32'hDEAD55EF, 1'b1};
    vt[10] = '{1'b1, 3'b001, 32'h101, 32'h1234,     32'h0,        32'hDEAD55EF, 1'b1};
    vt[11] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
    vt[12] = '{1'b0, 3'b011, 32'h104, 32'h0,        32'h0,        32'hCAFEF00D, 1'b1};
    vt[13] = '{1'b1, 3'b011, 32'h104, 32'h0,        32'h0,        32'hCAFEF00D, 1'b1};
    vt[14] = '{1'b0, 3'b110, 32'h100, 32'h0,        32'h0,        32'hCAFEF00D, 1'b1};
    vt[15] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h0,        32'hDEAD55EF, 1'b0};
    vt[16] = '{1'b1, 3'b010, 32'h400, 32'hA5A55A5A, 32'h0,        32'hDEAD55EF, 1'b0};
    vt[17] = '{1'b0, 3'b010, 32'h000, 32'h0,        32'h0,        32'hA5A55A5A, 1'b0};
    vt[18] = '{1'b0, 3'b010, 32'h108, 32'h0,        32'hFFFFFFFC, 32'hDEAD55EF, 1'b0};
    vt[19] = '{1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        32'hDEAD55EF, 1'b0};
    vt[20] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        32'hBEEFF00D, 1'b0};
    vt[21] = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h0,        32'hFFFFBEEF, 1'b0};
    vt[22] = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h0,        32'h000000F0, 1'b0};
    vt[23] = '{1'b0, 3'b000, 32'h100, 32'h0,        32'h0,        32'h0000000D, 1'b0};
    vt[24] = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        32'h0000000D, 1'b1};

    rst2 = 1'b0;
    rst4 = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_status2", status(1'b0), 32'b00);
      check("reset_status4", status(1'b1), 32'b00);
      check("reset_data2", bus2.mem_data, 32'h0);
      check("reset_data4", bus4.mem_data, 32'h0);
    end
    @(negedge clk);
    rst2 = 1'b1;
    rst4 = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_status2", status(1'b0), 32'b00);
      check("idle_status4", status(1'b1), 32'b00);
    end

    for (int i = 0; i < 25; i++)
      run_op(1'b0, vt[i].w, vt[i].bhw, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].exp_data, vt[i].exp_mis);

    // EN held high: accepts land on edges 0, 4 and 8.
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0BADF00D, 32'h0);
    repeat (3) q4.push_back('{32'h0, 1'b0});
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 8) set_req(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0BADF00D, 32'h0);
      check("handshake_status", status(1'b1), (k % 4 == 3) ? 32'b10 : 32'b01);
    end

    // EN pulse while busy must be dropped.
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0);
    q4.push_back('{32'h0BADF00D, 1'b0});
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0);
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 3'b010, 32'h200, 32'hFFFFFFFF, 32'h0);
    @(negedge clk);
    set_req(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'hFFFFFFFF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("pulse_done_timing", status(1'b1), 32'b10);
    repeat (6) begin
      @(posedge clk); #1;
      check("pulse_ignored", status(1'b1), 32'b00);
    end
    run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

    // Reset right after accept aborts the store.
    run_op(1'b1, 1'b1, 3'b010, 32'h20, 32'h22222222, 32'h0, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, 32'h0);
    rst4 = 1'b0;
    @(posedge clk); #1;
    rst4 = 1'b1;
    check("abort_status", status(1'b1), 32'b00);
    check("abort_data", bus4.mem_data, 32'h0);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_done", status(1'b1), 32'b00);
    end
    run_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 32'h22222222, 1'b0);

    // Reset landing exactly on the access edge also blocks the write.
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h33333333, 32'h0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h33333333, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0;
    @(posedge clk); #1;
    rst4 = 1'b1;
    check("abort_edge_status", status(1'b1), 32'b00);
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_edge_no_done", status(1'b1), 32'b00);
    end
    run_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 32'h22222222, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
